// File: rtl/kp_scanner.sv
// Matrix keypad scanner: walks one low column across the keypad, debounces press/release, reports a key code.
// Optional auto-repeat of key_press while held is built only when KP_REPEAT_EN is defined.
module kp_scanner #(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NROWS-1:0]                 kpr,
    output logic [NCOLS-1:0]                 kpc,
    output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
    output logic                             key_valid,
    output logic                             key_press,
    output logic                             key_release
);
    localparam int CODE_W = $clog2(NROWS*NCOLS);
    localparam int ROW_W  = $clog2(NROWS);
    localparam int COL_W  = $clog2(NCOLS);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOLS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    if (NROWS < 2 || NROWS > 8 || NCOLS < 2 || NCOLS > 8 || SETTLE_CYCLES < 1 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("kp_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] next_col;
    logic [ROW_W-1:0] row;
    logic [SET_W-1:0] settle_cnt;
    logic [DB_W-1:0]  db_cnt;

`ifdef KP_REPEAT_EN
    localparam int REP_W = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
`endif

    // Lowest-index low row wins when several rows are pulled down at once.
    function automatic logic [ROW_W-1:0] lowest_low(input logic [NROWS-1:0] rows);
        lowest_low = '0;
        for (int i = NROWS - 1; i >= 0; i--)
            if (!rows[i]) lowest_low = ROW_W'(i);
    endfunction

    function automatic logic [NCOLS-1:0] col_drive(input logic [COL_W-1:0] c);
        col_drive    = '1;
        col_drive[c] = 1'b0;
    endfunction

    always_comb begin
        next_col = (col == COL_LAST) ? '0 : col + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= SCAN;
            col         <= '0;
            kpc         <= col_drive('0);
            row         <= '0;
            settle_cnt  <= '0;
            db_cnt      <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KP_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                SCAN: begin
                    if (settle_cnt == SET_LAST) begin
                        settle_cnt <= '0;
                        if (&kpr) begin
                            col <= next_col;
                            kpc <= col_drive(next_col);
                        end else begin
                            row    <= lowest_low(kpr);
                            db_cnt <= '0;
                            state  <= DEBOUNCE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    // A bounce drops back to the same column so the key is re-tried immediately.
                    if (kpr[row]) begin
                        db_cnt     <= '0;
                        settle_cnt <= '0;
                        state      <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_code  <= CODE_W'(int'(row) * NCOLS + int'(col));
                        key_valid <= 1'b1;
                        key_press <= 1'b1;
                        db_cnt    <= '0;
                        state     <= HELD;
`ifdef KP_REPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (kpr[row]) begin
                        if (db_cnt == DB_LAST) begin
                            key_valid   <= 1'b0;
                            key_release <= 1'b1;
                            db_cnt      <= '0;
                            settle_cnt  <= '0;
                            col         <= next_col;
                            kpc         <= col_drive(next_col);
                            state       <= SCAN;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
`ifdef KP_REPEAT_EN
                    // Repeats fire only on low cycles, so they can never coincide with a release.
                    if (db_cnt != '0 || kpr[row]) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT)) begin
                        key_press <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_kp_scanner.sv
// Directed bench for kp_scanner (4x4, settle 2, debounce 4) with a one-key keypad model on row 2 / column 1.
// Define KP_REPEAT_EN for both files to also check the auto-repeat timing.
module tb_kp_scanner;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] key_code;
    logic       key_valid, key_press, key_release;

    logic key_down = 1'b0;
    logic glitch   = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   hit;

`ifdef KP_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    kp_scanner #(
        .NROWS(4), .NCOLS(4), .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .kpr(kpr), .kpc(kpc),
        .key_code(key_code), .key_valid(key_valid),
        .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Key at row 2 / column 1 only pulls its row low while its column is driven.
    always_comb begin
        kpr = 4'b1111;
        if ((key_down || glitch) && !kpc[1]) kpr[2] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_kpc"}, 32'(kpc), 32'hE);
        chk({tag, "_code"}, 32'(key_code), 0);
        chk({tag, "_valid"}, 32'(key_valid), 0);
        chk({tag, "_press"}, 32'(key_press), 0);
        chk({tag, "_release"}, 32'(key_release), 0);
    endtask

    initial begin
        logic [3:0] scan_seq [10];
        scan_seq = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE, 4'hE};

        // 1: reset
        repeat (3) tick();
        chk_idle_outs("s1");
        reset_n = 1'b1;

        // 2: idle scan, two cycles per column
        for (int t = 0; t < 10; t++) begin
            if (t > 0) tick();
            chk($sformatf("s2_kpc%0d", t), 32'(kpc), 32'(scan_seq[t]));
            chk($sformatf("s2_strobe%0d", t), 32'({key_press, key_release}), 0);
        end

        // 3: press key 9; press pulse 4 cycles after the sampling edge
        key_down = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("s3_kpc%0d", t), 32'(kpc), 32'hD);
            chk($sformatf("s3_press%0d", t), 32'(key_press), 32'(t == 7));
            chk($sformatf("s3_valid%0d", t), 32'(key_valid), 32'(t >= 7));
        end
        chk("s3_code", 32'(key_code), 9);

        // 5: release with a one-cycle low glitch restarting the release count
        key_down = 1'b0;
        tick();
        chk("s5_valid_a", 32'(key_valid), 1);
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        chk("s5_valid_b", 32'(key_valid), 1);
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk($sformatf("s5_release%0d", t), 32'(key_release), 32'(t == 4));
            chk($sformatf("s5_valid%0d", t), 32'(key_valid), 32'(t < 4));
            chk($sformatf("s5_press%0d", t), 32'(key_press), 0);
            chk($sformatf("s5_kpc%0d", t), 32'(kpc), (t >= 4) ? 32'hB : 32'hD);
        end
        chk("s5_code", 32'(key_code), 9);

        // 4: bounce of two low cycles on column 1
        hit = 0;
        for (int t = 0; t < 20 && hit == 0; t++) begin
            tick();
            if (kpc == 4'hD) hit = 1;
        end
        chk("s4_wait_col1", 32'(hit), 1);
        glitch = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (t == 2) glitch = 1'b0;
            chk($sformatf("s4_kpc%0d", t), 32'(kpc), (t == 5) ? 32'hB : 32'hD);
            chk($sformatf("s4_press%0d", t), 32'(key_press), 0);
            chk($sformatf("s4_valid%0d", t), 32'(key_valid), 0);
        end
        chk("s4_code", 32'(key_code), 9);

        // 6: press, hold 40 cycles (repeat timing if built), then reset while held
        key_down = 1'b1;
        hit = 0;
        for (int t = 0; t < 40 && hit == 0; t++) begin
            tick();
            if (key_press) hit = 1;
        end
        chk("s6_wait_press", 32'(hit), 1);
        for (int k = 1; k < 40; k++) begin
            tick();
            chk($sformatf("s6_rep%0d", k), 32'(key_press),
                32'(REP && k >= 20 && (k - 20) % 5 == 0));
            chk($sformatf("s6_valid%0d", k), 32'(key_valid), 1);
        end
        reset_n = 1'b0;
        tick();
        chk_idle_outs("s6_rst");
        reset_n  = 1'b1;
        key_down = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk($sformatf("s6_post_release%0d", t), 32'(key_release), 0);
            chk($sformatf("s6_post_valid%0d", t), 32'(key_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
